alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Multicycle execute-stage sequencer that sits directly upstream of the 16-bit `alu` and consumes its result. It latches operands and the operation from decode, drives the ALU's `control_bit`, `alu_in_1` and `alu_in_2` from internal temporaries, and captures `alu_out` and `z_val`. It computes carry locally, maintains the architectural C/Z flags, and issues a conditional register-file write-back with a `done` pulse.

## Interface
- No parameters. Datapath width is fixed at 16 bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request to accept one operation; sampled only in IDLE or WB.
- `opcode` in 2: 00 add, 01 sub, 10 nand, 11 nand (alias).
- `cond` in 2: write/flag condition.
  - 00: always.
  - 01: only if C=1.
  - 10: only if Z=1.
  - 11: never (NOP).
- `set_flags` in 1: permit flag update for this operation.
- `rega`, `regb` in 16: source operands.
- `alu_out` in 16: result from the ALU.
- `z_val` in 1: zero flag from the ALU.
- `control_bit` out 2: ALU operation select.
- `alu_in_1`, `alu_in_2` out 16: ALU operands, driven from the T1/T2 temporaries.
- `result` out 16: captured ALU result.
- `wr_en` out 1: one-cycle write-back strobe.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high in EXEC and WB.
- `c_flag`, `z_flag` out 1: architectural flags.

## Operation
States and transitions:
- IDLE →EXEC when `start`=1.
- EXEC →WB unconditionally.
- WB →EXEC when `start`=1.
- WB →IDLE otherwise.

Accept (the edge where `start`=1 in IDLE or WB):
- T1←`rega`, T2←`regb`.
- Latch `opcode`, `cond` and `set_flags`.

EXEC:
- `control_bit` = 00 for add, 01 for sub, 10 for opcode 10 or 11.
- `alu_in_1`=T1, `alu_in_2`=T2.
- Evaluate `cond_ok` against the current `c_flag`/`z_flag`.

At the EXEC→WB edge:
- `result`←`alu_out` (always captured, even when `cond_ok`=0).
- Local carry, from 17-bit arithmetic on T1/T2:
  - add: bit 16 of {0,T1}+{0,T2}.
  - sub: borrow, i.e. 1 when T1<T2 unsigned.
  - nand: no carry produced.
- If `cond_ok` and `set_flags`:
  - `z_flag`←`z_val`.
  - `c_flag`←local carry, for add and sub only.
  - nand leaves `c_flag` unchanged.
- Otherwise both flags hold.

WB:
- `wr_en` = `cond_ok` (registered).
- `done`=1.
- Updated flags are already visible in this cycle.

Other behaviour:
- `start` during EXEC is ignored; no queueing.
- Outside EXEC, `control_bit`, `alu_in_1` and `alu_in_2` hold their last values. The ALU output is don't-care then.
- Reset (asynchronous, any state including mid-EXEC or mid-WB) immediately forces:
  - state IDLE;
  - `wr_en`=`done`=`busy`=0;
  - `result`=0, `c_flag`=`z_flag`=0;
  - `control_bit`=00, `alu_in_1`=`alu_in_2`=0;
  - T1, T2 and latched controls = 0.
- An in-flight operation is discarded with no write.

## Timing
- Reset value of every output is 0.
- `start` accepted at edge k:
  - EXEC during cycle k..k+1;
  - `result`, flags, `wr_en`, `done` valid in cycle k+1..k+2 (latency 2 edges).
- `done` and `wr_en` are exactly one cycle wide, except in back-to-back operation (see below).
- Back-to-back issue: `start` sampled in WB gives one operation per 2 cycles.
  - The next operation's condition sees flags already updated by the previous one.
  - `done` deasserts for one cycle (the new EXEC) between operations.
- `busy` is a registered decode of the state: 1 in EXEC and WB.
- All outputs are registered, except `control_bit`, `alu_in_1` and `alu_in_2`, which are register-driven decodes of the state and temporaries.

## Test plan
- Add with carry-out: reset, then start with add, 0xFFFF + 0x0001, cond=00, set_flags=1.
  - ALU sees `control_bit`=00.
  - WB: `result`=0x0000, `z_flag`=1, `c_flag`=1, `wr_en`=1, `done`=1, two edges after start.
- Sub with borrow: start sub, 0x0005 − 0x0007, cond=00, set_flags=1.
  - `control_bit`=01.
  - `result`=0xFFFE, `c_flag`=1, `z_flag`=0.
- Nand: with `c_flag`=1, start nand, 0xFFFF, 0xFFFF, set_flags=1.
  - `result`=0x0000, `z_flag`=1, `c_flag` stays 1.
  - Repeat with opcode 11: identical response.
- Conditional skip and NOP:
  - With `c_flag`=0, start add, 3 + 4, cond=01: `result`=0x0007, `wr_en`=0, `done`=1, flags unchanged.
  - Same with cond=11: `wr_en`=0 regardless of flags.
- Back-to-back with flag dependency:
  - Op1: add 0x8000 + 0x8000 (sets C=1).
  - Op2: add 1 + 1, cond=01, with `start` held high in Op1's WB.
  - Op2: `wr_en`=1, `result`=0x0002, `done` high 2 cycles after Op1's `done`; `start` during EXEC ignored.
- Reset mid-operation: assert `rst_n`=0 asynchronously during EXEC.
  - All outputs drop to 0 within the same cycle, with no `wr_en`.
  - After release, a new add 1 + 1 completes normally with `result`=0x0002.

Source files
------------

// File: rtl/alu_exec_ctrl_if.sv
// Bundle of the decode-side request/response and ALU-side signals of the execute sequencer.
// The sequencer connects through the slave modport; the driving environment uses master.
interface alu_exec_ctrl_if;
    logic        start;
    logic [1:0]  opcode;
    logic [1:0]  cond;
    logic        set_flags;
    logic [15:0] rega;
    logic [15:0] regb;
    logic [15:0] alu_out;
    logic        z_val;
    logic [1:0]  control_bit;
    logic [15:0] alu_in_1;
    logic [15:0] alu_in_2;
    logic [15:0] result;
    logic        wr_en;
    logic        done;
    logic        busy;
    logic        c_flag;
    logic        z_flag;

    modport slave (
        input  start, opcode, cond, set_flags, rega, regb, alu_out, z_val,
        output control_bit, alu_in_1, alu_in_2, result, wr_en, done, busy,
               c_flag, z_flag
    );

    modport master (
        output start, opcode, cond, set_flags, rega, regb, alu_out, z_val,
        input  control_bit, alu_in_1, alu_in_2, result, wr_en, done, busy,
               c_flag, z_flag
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Two-cycle execute sequencer (IDLE/EXEC/WB) feeding a 16-bit ALU, owning the C/Z
// flags and issuing a conditional write-back strobe with a done pulse.
module alu_exec_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD      = 2'b00;
    localparam logic [1:0] OP_SUB      = 2'b01;
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_C      = 2'b01;
    localparam logic [1:0] COND_Z      = 2'b10;

    // Carry is derived from the operands rather than taken from the ALU.
    function automatic logic carry_of(input logic [1:0] op,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:  return sum[16];
            OP_SUB:  return (a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic cond_met(input logic [1:0] cnd,
                                      input logic       c,
                                      input logic       z);
        case (cnd)
            COND_ALWAYS: return 1'b1;
            COND_C:      return c;
            COND_Z:      return z;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] ctrl_of(input logic [1:0] op);
        if (op[1]) return 2'b10;
        return {1'b0, op[0]};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] t1_q, t2_q;
    logic [1:0]  op_q, cond_q;
    logic        set_flags_q;
    logic [15:0] result_q;
    logic        c_q, z_q;
    logic        wr_en_q, done_q, busy_q;

    logic        accept;
    logic        in_exec;
    logic        cond_ok;
    logic        flag_upd;
    logic        carry;

    assign accept   = bus.start && ((state_q == IDLE) || (state_q == WB));
    assign in_exec  = (state_q == EXEC);
    assign cond_ok  = cond_met(cond_q, c_q, z_q);
    assign flag_upd = in_exec && cond_ok && set_flags_q;
    assign carry    = carry_of(op_q, t1_q, t2_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = bus.start ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept: operands and controls only change on entry to EXEC, so the ALU
    // drive below naturally holds its last value outside EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_q        <= '0;
            t2_q        <= '0;
            op_q        <= '0;
            cond_q      <= '0;
            set_flags_q <= 1'b0;
        end else if (accept) begin
            t1_q        <= bus.rega;
            t2_q        <= bus.regb;
            op_q        <= bus.opcode;
            cond_q      <= bus.cond;
            set_flags_q <= bus.set_flags;
        end
    end

    // EXEC -> WB: capture the ALU result, update flags, raise the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wr_en_q <= in_exec && cond_ok;
            done_q  <= in_exec;
            busy_q  <= (state_d != IDLE);
            if (in_exec) begin
                result_q <= bus.alu_out;
            end
            if (flag_upd) begin
                z_q <= bus.z_val;
                if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                    c_q <= carry;
                end
            end
        end
    end

    assign bus.control_bit = ctrl_of(op_q);
    assign bus.alu_in_1    = t1_q;
    assign bus.alu_in_2    = t2_q;
    assign bus.result      = result_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
    assign bus.c_flag      = c_q;
    assign bus.z_flag      = z_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed table, back-to-back and reset sequences,
// then random operations against a flag/result reference model.
module tb_alu_exec_ctrl;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream 16-bit ALU.
    always_comb begin
        bus.alu_out = 16'h0000;
        case (bus.control_bit)
            2'b00:   bus.alu_out = bus.alu_in_1 + bus.alu_in_2;
            2'b01:   bus.alu_out = bus.alu_in_1 - bus.alu_in_2;
            default: bus.alu_out = ~(bus.alu_in_1 & bus.alu_in_2);
        endcase
        bus.z_val = (bus.alu_out == 16'h0000);
    end

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  cnd;
        logic        sf;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic        exp_c;
        logic        exp_z;
        logic        exp_wr;
    } vec_t;

    vec_t tbl [10];

    logic        mc, mz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_ctrl(input logic [1:0] op);
        case (op)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [1:0] op, input logic [1:0] cnd,
                         input logic sf, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic ec, input logic ez,
                         input logic ew);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.cond = cnd; bus.set_flags = sf;
        bus.rega = a; bus.regb = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.rega = ~a; bus.regb = ~b;
        check({tag, " exec busy"}, {31'd0, bus.busy}, 32'd1);
        check({tag, " exec done"}, {31'd0, bus.done}, 32'd0);
        check({tag, " ctrl"}, {30'd0, bus.control_bit}, {30'd0, exp_ctrl(op)});
        check({tag, " in1"}, {16'd0, bus.alu_in_1}, {16'd0, a});
        check({tag, " in2"}, {16'd0, bus.alu_in_2}, {16'd0, b});
        @(posedge clk); #1;
        check({tag, " result"}, {16'd0, bus.result}, {16'd0, er});
        check({tag, " c_flag"}, {31'd0, bus.c_flag}, {31'd0, ec});
        check({tag, " z_flag"}, {31'd0, bus.z_flag}, {31'd0, ez});
        check({tag, " wr_en"}, {31'd0, bus.wr_en}, {31'd0, ew});
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        @(posedge clk); #1;
        check({tag, " done drop"}, {31'd0, bus.done}, 32'd0);
        check({tag, " wr drop"}, {31'd0, bus.wr_en}, 32'd0);
        check({tag, " idle busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " result"}, {16'd0, bus.result}, 32'd0);
        check({tag, " c"}, {31'd0, bus.c_flag}, 32'd0);
        check({tag, " z"}, {31'd0, bus.z_flag}, 32'd0);
        check({tag, " wr"}, {31'd0, bus.wr_en}, 32'd0);
        check({tag, " done"}, {31'd0, bus.done}, 32'd0);
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " ctrl"}, {30'd0, bus.control_bit}, 32'd0);
        check({tag, " in1"}, {16'd0, bus.alu_in_1}, 32'd0);
        check({tag, " in2"}, {16'd0, bus.alu_in_2}, 32'd0);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.opcode = 2'b00; bus.cond = 2'b00; bus.set_flags = 1'b0;
        bus.rega = 16'h0; bus.regb = 16'h0;

        //           op     cnd    sf    a        b        res      c     z     wr
        tbl[0] = '{2'b00, 2'b00, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{2'b01, 2'b00, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{2'b10, 2'b00, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{2'b11, 2'b00, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{2'b00, 2'b00, 1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{2'b00, 2'b01, 1'b1, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{2'b00, 2'b11, 1'b1, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{2'b01, 2'b10, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{2'b01, 2'b00, 1'b1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{2'b00, 2'b10, 1'b0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].cnd, tbl[i].sf, tbl[i].a,
                  tbl[i].b, tbl[i].exp_res, tbl[i].exp_c, tbl[i].exp_z, tbl[i].exp_wr);
        end

        // Back-to-back: op2 is conditional on the carry op1 produces.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 2'b00; bus.cond = 2'b00; bus.set_flags = 1'b1;
        bus.rega = 16'h8000; bus.regb = 16'h8000;
        @(posedge clk); #1;
        bus.cond = 2'b01; bus.rega = 16'h0001; bus.regb = 16'h0001;
        @(posedge clk); #1;
        check("b2b op1 result", {16'd0, bus.result}, 32'h0000);
        check("b2b op1 c", {31'd0, bus.c_flag}, 32'd1);
        check("b2b op1 z", {31'd0, bus.z_flag}, 32'd1);
        check("b2b op1 wr", {31'd0, bus.wr_en}, 32'd1);
        check("b2b op1 done", {31'd0, bus.done}, 32'd1);
        check("b2b exec start ignored", {16'd0, bus.alu_in_1}, 32'h8000);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b gap done", {31'd0, bus.done}, 32'd0);
        check("b2b gap wr", {31'd0, bus.wr_en}, 32'd0);
        check("b2b gap busy", {31'd0, bus.busy}, 32'd1);
        check("b2b op2 in1", {16'd0, bus.alu_in_1}, 32'h0001);
        @(posedge clk); #1;
        check("b2b op2 result", {16'd0, bus.result}, 32'h0002);
        check("b2b op2 wr", {31'd0, bus.wr_en}, 32'd1);
        check("b2b op2 done", {31'd0, bus.done}, 32'd1);
        check("b2b op2 c", {31'd0, bus.c_flag}, 32'd0);
        check("b2b op2 z", {31'd0, bus.z_flag}, 32'd0);
        @(posedge clk); #1;
        check("b2b end done", {31'd0, bus.done}, 32'd0);
        check("b2b end busy", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of EXEC.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = 2'b01; bus.cond = 2'b00; bus.set_flags = 1'b1;
        bus.rega = 16'h0005; bus.regb = 16'h0006;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("rst pre busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst post wr", {31'd0, bus.wr_en}, 32'd0);
        check("rst post done", {31'd0, bus.done}, 32'd0);
        do_op("rst recover", 2'b00, 2'b00, 1'b1, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0,
              1'b1);

        // Random operations against the reference model.
        mc = 1'b0; mz = 1'b0;
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  op, cnd;
            logic        sf, ok, w;
            logic [15:0] a, b, r;
            op  = 2'($urandom_range(0, 3));
            cnd = 2'($urandom_range(0, 3));
            sf  = 1'($urandom_range(0, 1));
            a   = pick_operand();
            b   = pick_operand();
            if (op == 2'b00)      r = a + b;
            else if (op == 2'b01) r = a - b;
            else                  r = ~(a & b);
            ok = (cnd == 2'b00) || (cnd == 2'b01 && mc) || (cnd == 2'b10 && mz);
            w  = ok;
            if (ok && sf) begin
                mz = (r == 16'h0000);
                if (op == 2'b00)      mc = ((32'(a) + 32'(b)) > 32'h0000_FFFF);
                else if (op == 2'b01) mc = (a < b);
            end
            do_op($sformatf("rnd%0d", n), op, cnd, sf, a, b, r, mc, mz, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
